// File: rtl/polilock_pkg.sv
// Shared constants for the Polilock password checker: FSM state encoding
// and the factory-default password.
package polilock_pkg;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    RECEBE    = 4'd1,
    DECIDE    = 4'd2,
    ACERTO    = 4'd3,
    ERRO      = 4'd4,
    BLOQUEADO = 4'd5,
    PROGRAMA  = 4'd6
  } estado_t;

  localparam logic [79:0] SENHA_PADRAO_ASCII = "VERILOGUEA";

endpackage

// File: rtl/contador_timeout.sv
// Saturating down-counter: limpar reloads MODULO-1, habilitar counts down,
// fim is high once MODULO enabled cycles have elapsed since the last clear.
module contador_timeout #(
  parameter int unsigned MODULO = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic limpar,
  input  logic habilitar,
  output logic fim
);

  localparam int unsigned W = $clog2(MODULO + 1);
  localparam logic [W-1:0] CARGA = W'(MODULO - 1);

  logic [W-1:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (limpar) begin
      cont_d = CARGA;
    end else if (habilitar && (cont_q != '0)) begin
      cont_d = cont_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_q <= CARGA;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign fim = (cont_q == '0);

endmodule

// File: rtl/verificador_senha_param.sv
// Password-check core: compares N_CHARS received bytes against a stored
// password, counts failures, locks out, and allows reprogramming after a hit.
//
// state     | meaning
// OCIOSO    | idle, waiting for iniciar
// RECEBE    | collecting entry bytes, inter-byte timeout running
// DECIDE    | one cycle to evaluate the mismatch flag
// ACERTO    | entry correct; iniciar restarts, programar enters PROGRAMA
// ERRO      | entry wrong or timed out; escalates to lockout at the limit
// BLOQUEADO | lockout timer running, all inputs ignored
// PROGRAMA  | collecting a new password into the shadow register
module verificador_senha_param
  import polilock_pkg::*;
#(
  parameter int unsigned N_BITS          = 8,
  parameter int unsigned N_CHARS         = 10,
  parameter logic [N_CHARS*N_BITS-1:0] SENHA_PADRAO = SENHA_PADRAO_ASCII,
  parameter int unsigned MAX_TENTATIVAS  = 3,
  parameter int unsigned BLOQUEIO_CICLOS = 500_000_000,
  parameter int unsigned TIMEOUT_CICLOS  = 250_000_000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 iniciar,
  input  logic                                 programar,
  input  logic [N_BITS-1:0]                    rx_dado,
  input  logic                                 rx_valido,
  output logic                                 acertou,
  output logic                                 errou,
  output logic                                 bloqueado,
  output logic                                 programado,
  output logic [3:0]                           db_estado,
  output logic [$clog2(N_CHARS+1)-1:0]         db_contagem,
  output logic [$clog2(MAX_TENTATIVAS+1)-1:0]  db_tentativas
);

  localparam int unsigned CW = $clog2(N_CHARS + 1);
  localparam int unsigned TW = $clog2(MAX_TENTATIVAS + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(N_CHARS - 1);
  localparam logic [TW-1:0] MAX_T  = TW'(MAX_TENTATIVAS);

  estado_t                      estado_q, estado_d;
  logic [CW-1:0]                indice_q, indice_d;
  logic                         difere_q, difere_d;
  logic [TW-1:0]                tentativas_q, tentativas_d;
  logic [N_CHARS*N_BITS-1:0]    senha_q, senha_d;
  logic [N_CHARS*N_BITS-1:0]    sombra_q, sombra_d;
  logic                         acertou_q, acertou_d;
  logic                         errou_q, errou_d;
  logic                         bloqueado_q, bloqueado_d;
  logic                         programado_q, programado_d;

  logic em_recepcao, fim_timeout, fim_bloqueio;
  logic [N_BITS-1:0] caractere;
  logic [TW-1:0] tentativas_inc;

  assign em_recepcao    = (estado_q == RECEBE) || (estado_q == PROGRAMA);
  assign caractere      = senha_q[(N_CHARS - 1 - int'(indice_q)) * N_BITS +: N_BITS];
  assign tentativas_inc = (tentativas_q == MAX_T) ? MAX_T : tentativas_q + TW'(1);

  // Any accepted byte (or a restart) rearms the inter-byte timeout.
  contador_timeout #(.MODULO(TIMEOUT_CICLOS)) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .limpar    (!em_recepcao || rx_valido || (iniciar && estado_q == RECEBE)),
    .habilitar (em_recepcao),
    .fim       (fim_timeout)
  );

  contador_timeout #(.MODULO(BLOQUEIO_CICLOS)) u_bloqueio (
    .clock     (clock),
    .reset     (reset),
    .limpar    (estado_q != BLOQUEADO),
    .habilitar (estado_q == BLOQUEADO),
    .fim       (fim_bloqueio)
  );

  always_comb begin
    estado_d     = estado_q;
    indice_d     = indice_q;
    difere_d     = difere_q;
    tentativas_d = tentativas_q;
    senha_d      = senha_q;
    sombra_d     = sombra_q;
    acertou_d    = acertou_q;
    errou_d      = errou_q;
    bloqueado_d  = bloqueado_q;
    programado_d = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          estado_d = RECEBE;
          indice_d = '0;
          difere_d = 1'b0;
        end
      end
      RECEBE: begin
        if (iniciar) begin
          indice_d = '0;
          difere_d = 1'b0;
        end else if (rx_valido) begin
          difere_d = difere_q | (rx_dado != caractere);
          indice_d = indice_q + CW'(1);
          if (indice_q == ULTIMO) estado_d = DECIDE;
        end else if (fim_timeout) begin
          estado_d     = ERRO;
          errou_d      = 1'b1;
          tentativas_d = tentativas_inc;
        end
      end
      DECIDE: begin
        if (!difere_q) begin
          estado_d     = ACERTO;
          acertou_d    = 1'b1;
          tentativas_d = '0;
        end else begin
          estado_d     = ERRO;
          errou_d      = 1'b1;
          tentativas_d = tentativas_inc;
        end
      end
      ACERTO: begin
        if (iniciar) begin
          estado_d  = RECEBE;
          acertou_d = 1'b0;
          indice_d  = '0;
          difere_d  = 1'b0;
        end else if (programar) begin
          estado_d  = PROGRAMA;
          acertou_d = 1'b0;
          indice_d  = '0;
        end
      end
      PROGRAMA: begin
        // Bytes land in the shadow copy; the live password changes only on completion.
        if (rx_valido) begin
          sombra_d[(N_CHARS - 1 - int'(indice_q)) * N_BITS +: N_BITS] = rx_dado;
          indice_d = indice_q + CW'(1);
          if (indice_q == ULTIMO) begin
            senha_d      = sombra_d;
            programado_d = 1'b1;
            estado_d     = OCIOSO;
          end
        end else if (fim_timeout) begin
          estado_d = OCIOSO;
        end
      end
      ERRO: begin
        if (tentativas_q == MAX_T) begin
          estado_d    = BLOQUEADO;
          bloqueado_d = 1'b1;
        end else if (iniciar) begin
          estado_d = RECEBE;
          errou_d  = 1'b0;
          indice_d = '0;
          difere_d = 1'b0;
        end
      end
      BLOQUEADO: begin
        if (fim_bloqueio) begin
          estado_d     = OCIOSO;
          bloqueado_d  = 1'b0;
          errou_d      = 1'b0;
          tentativas_d = '0;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= OCIOSO;
      indice_q     <= '0;
      difere_q     <= 1'b0;
      tentativas_q <= '0;
      senha_q      <= SENHA_PADRAO;
      sombra_q     <= SENHA_PADRAO;
      acertou_q    <= 1'b0;
      errou_q      <= 1'b0;
      bloqueado_q  <= 1'b0;
      programado_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      indice_q     <= indice_d;
      difere_q     <= difere_d;
      tentativas_q <= tentativas_d;
      senha_q      <= senha_d;
      sombra_q     <= sombra_d;
      acertou_q    <= acertou_d;
      errou_q      <= errou_d;
      bloqueado_q  <= bloqueado_d;
      programado_q <= programado_d;
    end
  end

  assign acertou       = acertou_q;
  assign errou         = errou_q;
  assign bloqueado     = bloqueado_q;
  assign programado    = programado_q;
  assign db_estado     = estado_q;
  assign db_contagem   = indice_q;
  assign db_tentativas = tentativas_q;

endmodule

// File: tb/tb_verificador_senha_param.sv
// Directed bench for verificador_senha_param with a 4-character password,
// short timeout and lockout so every boundary is reachable.
module tb_verificador_senha_param;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       programar;
  logic [7:0] rx_dado;
  logic       rx_valido;
  logic       acertou;
  logic       errou;
  logic       bloqueado;
  logic       programado;
  logic [3:0] db_estado;
  logic [2:0] db_contagem;
  logic [1:0] db_tentativas;

  int vetores = 0;
  int erros   = 0;

  verificador_senha_param #(
    .N_BITS          (8),
    .N_CHARS         (4),
    .SENHA_PADRAO    ("ABCD"),
    .MAX_TENTATIVAS  (3),
    .BLOQUEIO_CICLOS (100),
    .TIMEOUT_CICLOS  (50)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .programar     (programar),
    .rx_dado       (rx_dado),
    .rx_valido     (rx_valido),
    .acertou       (acertou),
    .errou         (errou),
    .bloqueado     (bloqueado),
    .programado    (programado),
    .db_estado     (db_estado),
    .db_contagem   (db_contagem),
    .db_tentativas (db_tentativas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    vetores++;
    if (obtido !== esperado) begin
      erros++;
      $display("FAIL %s: got %0h expected %0h", tag, obtido, esperado);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulso_iniciar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic envia_byte(input logic [7:0] b);
    rx_dado   = b;
    rx_valido = 1'b1;
    tick();
    rx_valido = 1'b0;
  endtask

  task automatic envia_str(input logic [31:0] s);
    for (int i = 0; i < 4; i++) envia_byte(s[31-8*i -: 8]);
  endtask

  task automatic confere_saidas(input string tag, input logic a, input logic e, input logic b,
                                input logic [3:0] est, input logic [1:0] tent);
    verifica({tag, ".acertou"},    acertou,       a);
    verifica({tag, ".errou"},      errou,         e);
    verifica({tag, ".bloqueado"},  bloqueado,     b);
    verifica({tag, ".estado"},     db_estado,     est);
    verifica({tag, ".tentativas"}, db_tentativas, tent);
  endtask

  initial begin
    reset     = 1'b0;
    iniciar   = 1'b0;
    programar = 1'b0;
    rx_dado   = 8'h00;
    rx_valido = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    confere_saidas("rst", 0, 0, 0, 4'd0, 2'd0);
    verifica("rst.programado", programado, 0);
    verifica("rst.contagem", db_contagem, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // correct entry, exact latency
    pulso_iniciar();
    envia_str("ABCD");
    verifica("ok.decide_estado", db_estado, 4'd2);
    verifica("ok.decide_acertou", acertou, 0);
    tick();
    confere_saidas("ok", 1, 0, 0, 4'd3, 2'd0);
    verifica("ok.contagem", db_contagem, 4);

    // three failures -> lockout
    for (int k = 1; k <= 3; k++) begin
      pulso_iniciar();
      envia_str("ABXD");
      tick();
      confere_saidas($sformatf("falha%0d", k), 0, 1, 0, 4'd4, 2'(k));
    end
    tick();
    confere_saidas("bloq.entrada", 0, 1, 1, 4'd5, 2'd3);
    pulso_iniciar();
    envia_str("ABCD");
    confere_saidas("bloq.ignora", 0, 1, 1, 4'd5, 2'd3);
    repeat (94) tick();
    confere_saidas("bloq.ultimo", 0, 1, 1, 4'd5, 2'd3);
    tick();
    confere_saidas("bloq.fim", 0, 0, 0, 4'd0, 2'd0);

    // inter-byte timeout
    pulso_iniciar();
    envia_byte("A");
    envia_byte("B");
    repeat (49) tick();
    verifica("to.antes_estado", db_estado, 4'd1);
    verifica("to.antes_errou", errou, 0);
    tick();
    confere_saidas("to", 0, 1, 0, 4'd4, 2'd1);
    pulso_iniciar();
    envia_str("ABCD");
    tick();
    confere_saidas("to.recupera", 1, 0, 0, 4'd3, 2'd0);

    // restart mid-entry; iniciar wins over a simultaneous byte
    pulso_iniciar();
    envia_byte("A");
    envia_byte("B");
    verifica("rein.contagem_ab", db_contagem, 2);
    iniciar   = 1'b1;
    rx_valido = 1'b1;
    rx_dado   = "X";
    tick();
    iniciar   = 1'b0;
    rx_valido = 1'b0;
    verifica("rein.contagem_zero", db_contagem, 0);
    envia_str("ABCD");
    tick();
    confere_saidas("rein", 1, 0, 0, 4'd3, 2'd0);

    // reprogramming
    programar = 1'b1;
    tick();
    programar = 1'b0;
    verifica("prog.estado", db_estado, 4'd6);
    verifica("prog.acertou", acertou, 0);
    envia_byte("W");
    envia_byte("X");
    envia_byte("Y");
    verifica("prog.antes", programado, 0);
    envia_byte("Z");
    verifica("prog.pulso", programado, 1);
    verifica("prog.ocioso", db_estado, 4'd0);
    tick();
    verifica("prog.pulso_fim", programado, 0);
    pulso_iniciar();
    envia_str("ABCD");
    tick();
    confere_saidas("prog.velha", 0, 1, 0, 4'd4, 2'd1);
    pulso_iniciar();
    envia_str("WXYZ");
    tick();
    confere_saidas("prog.nova", 1, 0, 0, 4'd3, 2'd0);

    // reset mid-programming restores the default password
    programar = 1'b1;
    tick();
    programar = 1'b0;
    envia_byte("W");
    envia_byte("X");
    reset = 1'b0;
    #2;
    confere_saidas("rstprog", 0, 0, 0, 4'd0, 2'd0);
    verifica("rstprog.contagem", db_contagem, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    pulso_iniciar();
    envia_str("ABCD");
    tick();
    confere_saidas("rstprog.padrao", 1, 0, 0, 4'd3, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
